// File: rtl/gte_seq_pkg.sv
// Shared definitions for the GTE microcode sequencer: widths, opcodes, command field
// positions, sequencer state and the opcode -> microcode start address table.
package gte_seq_pkg;

  localparam int unsigned SEQ_PC_W  = 9;
  localparam int unsigned SEQ_CMD_W = 25;
  localparam int unsigned OP_W      = 6;

  // Command word field positions
  localparam int unsigned CMD_SF_BIT = 19;
  localparam int unsigned CMD_MX_LSB = 17;
  localparam int unsigned CMD_V_LSB  = 15;
  localparam int unsigned CMD_CV_LSB = 13;
  localparam int unsigned CMD_LM_BIT = 10;
  localparam int unsigned CMD_OP_LSB = 0;

  localparam logic [OP_W-1:0] RTPS  = 6'h01;
  localparam logic [OP_W-1:0] NCLIP = 6'h06;
  localparam logic [OP_W-1:0] OP    = 6'h0C;
  localparam logic [OP_W-1:0] DPCS  = 6'h10;
  localparam logic [OP_W-1:0] INTPL = 6'h11;
  localparam logic [OP_W-1:0] MVMVA = 6'h12;
  localparam logic [OP_W-1:0] NCDS  = 6'h13;
  localparam logic [OP_W-1:0] CDP   = 6'h14;
  localparam logic [OP_W-1:0] NCDT  = 6'h16;
  localparam logic [OP_W-1:0] NCCS  = 6'h1B;
  localparam logic [OP_W-1:0] CC    = 6'h1C;
  localparam logic [OP_W-1:0] NCS   = 6'h1E;
  localparam logic [OP_W-1:0] NCT   = 6'h20;
  localparam logic [OP_W-1:0] SQR   = 6'h28;
  localparam logic [OP_W-1:0] DCPL  = 6'h29;
  localparam logic [OP_W-1:0] DPCT  = 6'h2A;
  localparam logic [OP_W-1:0] AVSZ3 = 6'h2D;
  localparam logic [OP_W-1:0] AVSZ4 = 6'h2E;
  localparam logic [OP_W-1:0] RTPT  = 6'h30;
  localparam logic [OP_W-1:0] GPF   = 6'h3D;
  localparam logic [OP_W-1:0] GPL   = 6'h3E;
  localparam logic [OP_W-1:0] NCCT  = 6'h3F;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic       sf;
    logic [1:0] mx;
    logic [1:0] v;
    logic [1:0] cv;
    logic       lm;
  } cmd_fields_t;

  // Start addresses match the microcode image layout; entry 0 is the NOP.
  function automatic logic [SEQ_PC_W-1:0] START_PC(input logic [OP_W-1:0] op);
    logic [SEQ_PC_W-1:0] pc;
    case (op)
      RTPS:    pc = 9'd8;
      NCLIP:   pc = 9'd16;
      OP:      pc = 9'd24;
      DPCS:    pc = 9'd32;
      INTPL:   pc = 9'd40;
      MVMVA:   pc = 9'd48;
      NCDS:    pc = 9'd64;
      CDP:     pc = 9'd80;
      NCDT:    pc = 9'd96;
      NCCS:    pc = 9'd128;
      CC:      pc = 9'd144;
      NCS:     pc = 9'd160;
      NCT:     pc = 9'd176;
      SQR:     pc = 9'd200;
      DCPL:    pc = 9'd208;
      DPCT:    pc = 9'd216;
      AVSZ3:   pc = 9'd232;
      AVSZ4:   pc = 9'd240;
      RTPT:    pc = 9'd256;
      GPF:     pc = 9'd288;
      GPL:     pc = 9'd304;
      NCCT:    pc = 9'd320;
      default: pc = 9'd0;
    endcase
    return pc;
  endfunction

endpackage

// File: rtl/gte_cmd_decode.sv
// Combinational COP2 command decode: opcode -> microcode start address, plus
// extraction of the modifier fields handed to the datapath.
module gte_cmd_decode
  import gte_seq_pkg::*;
#(
  parameter int unsigned PC_W  = SEQ_PC_W,
  parameter int unsigned CMD_W = SEQ_CMD_W
) (
  input  logic [CMD_W-1:0] i_cmd,
  output logic [PC_W-1:0]  o_start_pc_c,
  output cmd_fields_t      o_fields_c
);

  logic [OP_W-1:0] w_op;
  logic            w_unused;

  // Bits of the command word that carry nothing for the sequencer
  assign w_unused = ^{i_cmd[CMD_W-1:CMD_SF_BIT+1], i_cmd[CMD_CV_LSB-1:CMD_LM_BIT+1],
                      i_cmd[CMD_LM_BIT-1:CMD_OP_LSB+OP_W]};

  always_comb begin
    w_op          = i_cmd[CMD_OP_LSB +: OP_W];
    o_start_pc_c  = PC_W'(START_PC(w_op));
    o_fields_c.sf = i_cmd[CMD_SF_BIT];
    o_fields_c.mx = i_cmd[CMD_MX_LSB +: 2];
    o_fields_c.v  = i_cmd[CMD_V_LSB +: 2];
    o_fields_c.cv = i_cmd[CMD_CV_LSB +: 2];
    o_fields_c.lm = i_cmd[CMD_LM_BIT];
  end

endmodule

// File: rtl/gte_microcode_sequencer.sv
// GTE microcode sequencer: starts a command at its microcode entry, steps the ROM PC each
// unstalled cycle until the ROM flags the last entry, and holds the command modifiers.
module gte_microcode_sequencer
  import gte_seq_pkg::*;
#(
  parameter int unsigned PC_W  = SEQ_PC_W,
  parameter int unsigned CMD_W = SEQ_CMD_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CMD_W-1:0] i_cmd,
  input  logic             i_stall,
  input  logic             i_lastInstr,
  output logic [PC_W-1:0]  o_PC,
  output logic             o_isNewInstr,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic             o_sf,
  output logic             o_lm,
  output logic [1:0]       o_mx,
  output logic [1:0]       o_v,
  output logic [1:0]       o_cv
);

  localparam logic [PC_W-1:0] PC_LAST = '1;

  seq_state_e      r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_start_pc;
  logic            r_new, w_new_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_error, w_error_nxt;
  cmd_fields_t     r_fld, w_fld_nxt, w_dec_fld;

  gte_cmd_decode #(
    .PC_W  (PC_W),
    .CMD_W (CMD_W)
  ) u_cmd_decode (
    .i_cmd        (i_cmd),
    .o_start_pc_c (w_start_pc),
    .o_fields_c   (w_dec_fld)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_new   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_fld   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_new   <= w_new_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
      r_fld   <= w_fld_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_new_nxt   = r_new;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_error_nxt = r_error;
    w_fld_nxt   = r_fld;
    case (r_state)
      ST_IDLE: begin
        w_pc_nxt = '0;
        if (i_start) begin
          w_fld_nxt   = w_dec_fld;
          w_pc_nxt    = w_start_pc;
          w_new_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_error_nxt = 1'b0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // A stall freezes the step, so lastInstr for the held entry is not yet acted on
        if (!i_stall) begin
          if (i_lastInstr) begin
            w_pc_nxt    = '0;
            w_new_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (r_pc == PC_LAST) begin
            w_pc_nxt    = '0;
            w_new_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_error_nxt = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_pc_nxt  = r_pc + PC_W'(1);
            w_new_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_pc_nxt    = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_PC         = r_pc;
  assign o_isNewInstr = r_new;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_sf         = r_fld.sf;
  assign o_lm         = r_fld.lm;
  assign o_mx         = r_fld.mx;
  assign o_v          = r_fld.v;
  assign o_cv         = r_fld.cv;

endmodule
